// File: rtl/sys_bus_ctrl_pkg.sv
// Shared types and register-map constants for the system bus controller.
// Imported by the top level and the RX FIFO.
package sys_bus_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_MMIO_RESP = 3'd1,
    ST_MEM_WAIT  = 3'd2,
    ST_MEM_RESP  = 3'd3,
    ST_IRQ_RESP  = 3'd4
  } bus_state_e;

  // Register offsets inside one channel's 4-word MMIO slot
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  // Status bit positions
  localparam int STAT_RX_NE    = 0;
  localparam int STAT_TX_READY = 1;
  localparam int STAT_RX_OVF   = 2;
  localparam int STAT_TX_DROP  = 3;
  localparam int STAT_CNT_LSB  = 4;

  function automatic logic [15:0] pack_status(input logic [3:0] count,
                                              input logic       tx_drop,
                                              input logic       rx_ovf,
                                              input logic       tx_ready,
                                              input logic       not_empty);
    logic [15:0] s;
    s = 16'h0000;
    s[STAT_CNT_LSB +: 4] = count;
    s[STAT_TX_DROP]      = tx_drop;
    s[STAT_RX_OVF]       = rx_ovf;
    s[STAT_TX_READY]     = tx_ready;
    s[STAT_RX_NE]        = not_empty;
    return s;
  endfunction

endpackage

// File: rtl/sys_bus_ctrl_rx_fifo.sv
// Per-channel receive FIFO; a read of an empty FIFO yields zero, and a push
// into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module rx_fifo
  import sys_bus_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       I_clk,
  input  logic                       I_reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];
  assign count   = cnt;

  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge I_clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/sys_bus_ctrl.sv
// System bus controller: address decode to bootrom/RAM/UART MMIO, memory
// latency sequencing, per-channel RX buffering and a fixed-priority IRQ unit.
module sys_bus_ctrl
  import sys_bus_ctrl_pkg::*;
#(
  parameter int          NUM_UART    = 2,
  parameter int          RX_DEPTH    = 4,
  parameter logic [15:0] BOOT_LIMIT  = 16'h0064,
  parameter logic [15:0] MMIO_BASE   = 16'h0400,
  parameter int          MEM_LATENCY = 2
) (
  input  logic                  I_clk,
  input  logic                  I_reset,
  input  logic                  MEM_exec,
  input  logic                  MEM_write,
  input  logic [1:0]            MEM_size,
  input  logic [15:0]           MEM_addr,
  input  logic [15:0]           MEM_data_out,
  output logic [15:0]           MEM_data_in,
  output logic                  MEM_ready,
  output logic                  MEM_data_ready,
  output logic                  O_irq_active,
  input  logic                  I_irq_ack,
  output logic                  RAM_enable,
  output logic                  RAM_write,
  output logic                  BOOT_enable,
  output logic [15:0]           RAM_data_in,
  input  logic [15:0]           RAM_data_out,
  input  logic [15:0]           BOOT_data_out,
  input  logic [NUM_UART-1:0]   UART_rx_data_ready,
  input  logic [8*NUM_UART-1:0] UART_rx_data,
  input  logic [NUM_UART-1:0]   UART_tx_ready,
  output logic [NUM_UART-1:0]   UART_tx_exec,
  output logic [8*NUM_UART-1:0] UART_tx_data
);

  localparam int          CNT_W    = $clog2(RX_DEPTH) + 1;
  localparam logic [16:0] MMIO_LO  = {1'b0, MMIO_BASE};
  localparam logic [16:0] MMIO_HI  = MMIO_LO + 17'(4 * NUM_UART);
  localparam logic [7:0]  LAT_LAST = 8'(MEM_LATENCY - 1);

  // Lowest-index pending channel wins; ids are 1-based so 0 means spurious.
  function automatic logic [15:0] irq_id(input logic [NUM_UART-1:0] pend);
    logic [15:0] id;
    id = 16'h0000;
    for (int c = NUM_UART - 1; c >= 0; c--) begin
      if (pend[c]) id = 16'(c + 1);
    end
    return id;
  endfunction

  bus_state_e            state_q, state_nxt;
  logic                  mem_ready_q, mem_ready_nxt;
  logic                  data_ready_q, data_ready_nxt;
  logic [15:0]           data_in_q, data_in_nxt;
  logic                  ram_en_q, ram_en_nxt;
  logic                  ram_wr_q, ram_wr_nxt;
  logic [15:0]           ram_din_q, ram_din_nxt;
  logic                  boot_en_q, boot_en_nxt;
  logic                  booting_q, booting_nxt;
  logic                  rd_q, rd_nxt;
  logic                  boot_sel_q, boot_sel_nxt;
  logic [7:0]            lat_cnt_q, lat_cnt_nxt;
  logic [NUM_UART-1:0]   tx_exec_q, tx_exec_nxt;
  logic [8*NUM_UART-1:0] tx_data_q, tx_data_nxt;
  logic [NUM_UART-1:0]   rx_ie_q, rx_ie_nxt;
  logic [NUM_UART-1:0]   rx_ovf_q, rx_ovf_nxt;
  logic [NUM_UART-1:0]   tx_drop_q, tx_drop_nxt;
  logic                  irq_q;

  logic [7:0]            fifo_dout  [NUM_UART];
  logic [CNT_W-1:0]      fifo_count [NUM_UART];
  logic [NUM_UART-1:0]   fifo_empty;
  logic [NUM_UART-1:0]   fifo_full;
  logic [NUM_UART-1:0]   fifo_pop;
  logic [NUM_UART-1:0]   pending;
  logic                  mmio_hit;
  logic [15:0]           mmio_off;
  logic                  unused_size;

  assign unused_size = &{1'b0, MEM_size};

  for (genvar c = 0; c < NUM_UART; c++) begin : g_rx
    rx_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
      .I_clk   (I_clk),
      .I_reset (I_reset),
      .push    (UART_rx_data_ready[c]),
      .pop     (fifo_pop[c]),
      .din     (UART_rx_data[8*c +: 8]),
      .dout    (fifo_dout[c]),
      .empty   (fifo_empty[c]),
      .full    (fifo_full[c]),
      .count   (fifo_count[c])
    );
  end

  assign mmio_hit = ({1'b0, MEM_addr} >= MMIO_LO) && ({1'b0, MEM_addr} < MMIO_HI);
  assign mmio_off = MEM_addr - MMIO_BASE;
  assign pending  = rx_ie_q & ~fifo_empty;

  assign MEM_data_in    = data_in_q;
  assign MEM_ready      = mem_ready_q;
  assign MEM_data_ready = data_ready_q;
  assign RAM_enable     = ram_en_q;
  assign RAM_write      = ram_wr_q;
  assign RAM_data_in    = ram_din_q;
  assign BOOT_enable    = boot_en_q;
  assign UART_tx_exec   = tx_exec_q;
  assign UART_tx_data   = tx_data_q;
  // The core must not see the line while its acknowledge is being answered.
  assign O_irq_active   = irq_q && (state_q != ST_IRQ_RESP);

  always_comb begin
    state_nxt      = state_q;
    mem_ready_nxt  = mem_ready_q;
    data_ready_nxt = 1'b0;
    data_in_nxt    = data_in_q;
    ram_en_nxt     = ram_en_q;
    ram_wr_nxt     = ram_wr_q;
    ram_din_nxt    = ram_din_q;
    boot_en_nxt    = boot_en_q;
    booting_nxt    = booting_q;
    rd_nxt         = rd_q;
    boot_sel_nxt   = boot_sel_q;
    lat_cnt_nxt    = lat_cnt_q;
    tx_exec_nxt    = '0;
    tx_data_nxt    = tx_data_q;
    rx_ie_nxt      = rx_ie_q;
    rx_ovf_nxt     = rx_ovf_q;
    tx_drop_nxt    = tx_drop_q;
    fifo_pop       = '0;

    case (state_q)
      ST_IDLE: begin
        if (I_irq_ack) begin
          mem_ready_nxt = 1'b0;
          state_nxt     = ST_IRQ_RESP;
        end else if (MEM_exec && mem_ready_q) begin
          mem_ready_nxt = 1'b0;
          if (mmio_hit) begin
            state_nxt = ST_MMIO_RESP;
            for (int c = 0; c < NUM_UART; c++) begin
              if (mmio_off[15:2] == 14'(c)) begin
                case (mmio_off[1:0])
                  REG_DATA: begin
                    if (MEM_write) begin
                      if (UART_tx_ready[c]) begin
                        tx_exec_nxt[c]        = 1'b1;
                        tx_data_nxt[8*c +: 8] = MEM_data_out[7:0];
                      end else begin
                        tx_drop_nxt[c] = 1'b1;
                      end
                    end else begin
                      fifo_pop[c] = 1'b1;
                      data_in_nxt = {8'h00, fifo_dout[c]};
                    end
                  end
                  REG_STATUS: begin
                    if (MEM_write) begin
                      rx_ovf_nxt[c]  = 1'b0;
                      tx_drop_nxt[c] = 1'b0;
                    end else begin
                      data_in_nxt = pack_status(4'(fifo_count[c]), tx_drop_q[c], rx_ovf_q[c],
                                                UART_tx_ready[c], !fifo_empty[c]);
                    end
                  end
                  REG_CTRL: begin
                    if (MEM_write) rx_ie_nxt[c] = MEM_data_out[0];
                    else           data_in_nxt  = {15'h0000, rx_ie_q[c]};
                  end
                  default: begin
                    if (!MEM_write) data_in_nxt = 16'h0000;
                  end
                endcase
              end
            end
          end else begin
            rd_nxt       = !MEM_write;
            lat_cnt_nxt  = 8'd0;
            state_nxt    = ST_MEM_WAIT;
            boot_sel_nxt = booting_q && !MEM_write && (MEM_addr < BOOT_LIMIT);
            if (booting_q && !MEM_write && (MEM_addr < BOOT_LIMIT)) begin
              boot_en_nxt = 1'b1;
            end else begin
              ram_en_nxt  = 1'b1;
              ram_wr_nxt  = MEM_write;
              ram_din_nxt = MEM_data_out;
            end
            // The first read above the boot region ends the boot phase for good.
            if (!MEM_write && (MEM_addr >= BOOT_LIMIT)) booting_nxt = 1'b0;
          end
        end
      end
      ST_MMIO_RESP: begin
        data_ready_nxt = 1'b1;
        mem_ready_nxt  = 1'b1;
        state_nxt      = ST_IDLE;
      end
      ST_MEM_WAIT: begin
        ram_en_nxt  = 1'b0;
        ram_wr_nxt  = 1'b0;
        boot_en_nxt = 1'b0;
        if (lat_cnt_q == LAT_LAST) state_nxt   = ST_MEM_RESP;
        else                       lat_cnt_nxt = lat_cnt_q + 8'd1;
      end
      ST_MEM_RESP: begin
        if (rd_q) data_in_nxt = boot_sel_q ? BOOT_data_out : RAM_data_out;
        data_ready_nxt = 1'b1;
        mem_ready_nxt  = 1'b1;
        state_nxt      = ST_IDLE;
      end
      ST_IRQ_RESP: begin
        data_in_nxt    = irq_id(pending);
        data_ready_nxt = 1'b1;
        mem_ready_nxt  = 1'b1;
        state_nxt      = ST_IDLE;
      end
      default: begin
        mem_ready_nxt = 1'b1;
        state_nxt     = ST_IDLE;
      end
    endcase

    // Overflow is evaluated last so it wins over a same-cycle status clear.
    for (int c = 0; c < NUM_UART; c++) begin
      if (UART_rx_data_ready[c] && fifo_full[c] && !fifo_pop[c]) rx_ovf_nxt[c] = 1'b1;
    end
  end

  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      state_q      <= ST_IDLE;
      mem_ready_q  <= 1'b1;
      data_ready_q <= 1'b0;
      data_in_q    <= 16'h0000;
      ram_en_q     <= 1'b0;
      ram_wr_q     <= 1'b0;
      ram_din_q    <= 16'h0000;
      boot_en_q    <= 1'b0;
      booting_q    <= 1'b1;
      rd_q         <= 1'b0;
      boot_sel_q   <= 1'b0;
      lat_cnt_q    <= 8'd0;
      tx_exec_q    <= '0;
      tx_data_q    <= '0;
      rx_ie_q      <= '0;
      rx_ovf_q     <= '0;
      tx_drop_q    <= '0;
      irq_q        <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      mem_ready_q  <= mem_ready_nxt;
      data_ready_q <= data_ready_nxt;
      data_in_q    <= data_in_nxt;
      ram_en_q     <= ram_en_nxt;
      ram_wr_q     <= ram_wr_nxt;
      ram_din_q    <= ram_din_nxt;
      boot_en_q    <= boot_en_nxt;
      booting_q    <= booting_nxt;
      rd_q         <= rd_nxt;
      boot_sel_q   <= boot_sel_nxt;
      lat_cnt_q    <= lat_cnt_nxt;
      tx_exec_q    <= tx_exec_nxt;
      tx_data_q    <= tx_data_nxt;
      rx_ie_q      <= rx_ie_nxt;
      rx_ovf_q     <= rx_ovf_nxt;
      tx_drop_q    <= tx_drop_nxt;
      irq_q        <= |pending;
    end
  end

endmodule
